// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding
// and the width of the step counter.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step on unsigned magnitudes: shift the
// {remainder, quotient} pair left, trial-subtract the divisor, keep or restore.
module div_restore_step #(
  parameter int N = 32
) (
  input  logic [N:0]   rem_i,
  input  logic [N-1:0] quo_i,
  input  logic [N-1:0] dvs_i,
  output logic [N:0]   rem_o,
  output logic [N-1:0] quo_o
);

  logic [N:0] shifted;
  logic [N:0] trial;

  // The extra remainder bit doubles as the sign of the trial subtraction.
  always_comb begin
    shifted = {rem_i[N-1:0], quo_i[N-1]};
    trial   = shifted - {1'b0, dvs_i};
    if (!trial[N]) begin
      rem_o = trial;
      quo_o = {quo_i[N-2:0], 1'b1};
    end else begin
      rem_o = shifted;
      quo_o = {quo_i[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: N restoring steps on magnitudes followed by a
// sign fix-up cycle, with a start/done handshake and registered results.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = count_width(N);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic          neg_a_q, neg_a_d;
  logic          neg_d_q, neg_d_d;
  logic          dz_q, dz_d;
  logic          ov_q, ov_d;
  logic          done_q, done_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          dz_out_q, dz_out_d;
  logic          ov_out_q, ov_out_d;

  logic [N-1:0]  a_mag, d_mag;
  logic [N:0]    step_rem;
  logic [N-1:0]  step_quo;
  logic [N-1:0]  q_fix, r_fix;

  div_restore_step #(.N(N)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Negating -2^(N-1) in N bits yields 2^(N-1), which is exact when read as unsigned.
  always_comb begin
    a_mag = dividend[N-1] ? (~dividend + 1'b1) : dividend;
    d_mag = divisor[N-1]  ? (~divisor + 1'b1)  : divisor;
    q_fix = (neg_a_q ^ neg_d_q) ? (~quo_q + 1'b1) : quo_q;
    if (dz_q) begin
      q_fix = '1;
    end
    r_fix = neg_a_q ? (~rem_q[N-1:0] + 1'b1) : rem_q[N-1:0];
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_a_d     = neg_a_q;
    neg_d_d     = neg_d_q;
    dz_d        = dz_q;
    ov_d        = ov_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_out_d    = dz_out_q;
    ov_out_d    = ov_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = d_mag;
          neg_a_d = dividend[N-1];
          neg_d_d = divisor[N-1];
          dz_d    = (divisor == '0);
          ov_d    = (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + 1'b1;
        if (count_q == CW'(N - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d  = q_fix;
        remainder_d = r_fix;
        dz_out_d    = dz_q;
        ov_out_d    = ov_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_a_q     <= 1'b0;
      neg_d_q     <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_out_q    <= 1'b0;
      ov_out_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_a_q     <= neg_a_d;
      neg_d_q     <= neg_d_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_out_q    <= dz_out_d;
      ov_out_q    <= ov_out_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_out_q;
  assign overflow    = ov_out_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed self-checking bench for seq_signed_divider: a 32-bit instance for
// the handshake and corner cases, an 8-bit instance for a model-based sweep.
module tb_seq_signed_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] quotient, remainder;
  logic        div_by_zero, overflow;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  q8, r8;
  logic        dz8, ov8;

  int checks = 0;
  int errors = 0;

  seq_signed_divider #(.N(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  seq_signed_divider #(.N(8)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start8),
    .dividend    (a8),
    .divisor     (b8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (q8),
    .remainder   (r8),
    .div_by_zero (dz8),
    .overflow    (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one 32-bit operation and count edges until done (bounded).
  task automatic op32(input logic [31:0] a, input logic [31:0] b, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
    a8     = a;
    b8     = b;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat    = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic sweep8(input logic [7:0] a, input logic [7:0] b);
    int         lat, ai, bi, qi, ri;
    logic [7:0] qe, re, inv;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      qe = 8'hFF;
      re = a;
    end else if (ai == -128 && bi == -1) begin
      qe = 8'h80;
      re = 8'h00;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      qe = qi[7:0];
      re = ri[7:0];
    end
    op8(a, b, lat);
    chk($sformatf("n8_lat %0d/%0d", ai, bi), lat, 32'd9);
    chk($sformatf("n8_q %0d/%0d", ai, bi), {24'd0, q8}, {24'd0, qe});
    chk($sformatf("n8_r %0d/%0d", ai, bi), {24'd0, r8}, {24'd0, re});
    chk($sformatf("n8_dz %0d/%0d", ai, bi), {31'd0, dz8}, {31'd0, (bi == 0)});
    chk($sformatf("n8_ov %0d/%0d", ai, bi), {31'd0, ov8}, {31'd0, (ai == -128 && bi == -1)});
    inv = q8 * b8 + r8;
    chk($sformatf("n8_inv %0d/%0d", ai, bi), {24'd0, inv}, {24'd0, a});
  endtask

  int          lat, ndone, dlat, cyc, last, idx;
  logic [31:0] bb_a [3];
  logic [31:0] bb_b [3];
  logic [31:0] bb_q [3];
  logic [31:0] bb_r [3];
  logic [7:0]  edge_a [8];
  logic [7:0]  edge_b [7];

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    start8   = 1'b0;
    a8       = '0;
    b8       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_ov", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] sign combinations");
    op32(32'd100, 32'd7, lat);
    chk("p_p_lat", lat, 32'd33);
    chk("p_p_q", quotient, 32'd14);
    chk("p_p_r", remainder, 32'd2);
    chk("p_p_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("hold_q", quotient, 32'd14);
    op32(-32'sd100, 32'd7, lat);
    chk("n_p_lat", lat, 32'd33);
    chk("n_p_q", quotient, -32'sd14);
    chk("n_p_r", remainder, -32'sd2);
    op32(32'd100, -32'sd7, lat);
    chk("p_n_q", quotient, -32'sd14);
    chk("p_n_r", remainder, 32'd2);
    op32(-32'sd100, -32'sd7, lat);
    chk("n_n_q", quotient, 32'd14);
    chk("n_n_r", remainder, -32'sd2);

    $display("[TB] overflow and divide by zero");
    op32(32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("ov_lat", lat, 32'd33);
    chk("ov_q", quotient, 32'h8000_0000);
    chk("ov_r", remainder, 32'd0);
    chk("ov_flag", {31'd0, overflow}, 32'd1);
    chk("ov_dz", {31'd0, div_by_zero}, 32'd0);
    op32(32'd6, 32'd3, lat);
    chk("after_ov_q", quotient, 32'd2);
    chk("after_ov_flag", {31'd0, overflow}, 32'd0);
    op32(32'd1234, 32'd0, lat);
    chk("dz_lat", lat, 32'd33);
    chk("dz_q", quotient, 32'hFFFF_FFFF);
    chk("dz_r", remainder, 32'd1234);
    chk("dz_flag", {31'd0, div_by_zero}, 32'd1);
    op32(-32'sd1234, 32'd0, lat);
    chk("dzn_q", quotient, 32'hFFFF_FFFF);
    chk("dzn_r", remainder, -32'sd1234);
    op32(32'd7, 32'd2, lat);
    chk("after_dz_flag", {31'd0, div_by_zero}, 32'd0);

    $display("[TB] start while busy");
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    dlat  = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5 || c == 10) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        dlat = c;
        chk("ign_q", quotient, 32'd14);
        chk("ign_r", remainder, 32'd2);
      end
    end
    chk("ign_ndone", ndone, 32'd1);
    chk("ign_lat", dlat, 32'd33);

    $display("[TB] back-to-back");
    bb_a[0] = 32'd100;    bb_b[0] = 32'd7;     bb_q[0] = 32'd14;    bb_r[0] = 32'd2;
    bb_a[1] = -32'sd9;    bb_b[1] = 32'd4;     bb_q[1] = -32'sd2;   bb_r[1] = -32'sd1;
    bb_a[2] = 32'd77;     bb_b[2] = -32'sd8;   bb_q[2] = -32'sd9;   bb_r[2] = 32'd5;
    idx      = 0;
    dividend = bb_a[0];
    divisor  = bb_b[0];
    start    = 1'b1;
    @(posedge clk); #1;
    cyc  = 0;
    last = 0;
    while (idx < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        chk($sformatf("b2b_gap%0d", idx), cyc - last, (idx == 0) ? 32'd33 : 32'd34);
        chk($sformatf("b2b_q%0d", idx), quotient, bb_q[idx]);
        chk($sformatf("b2b_r%0d", idx), remainder, bb_r[idx]);
        last = cyc;
        idx++;
        if (idx < 3) begin
          dividend = bb_a[idx];
          divisor  = bb_b[idx];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_count", idx, 32'd3);

    $display("[TB] reset mid-operation");
    dividend = -32'sd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op32(32'd9, 32'd2, lat);
    chk("post_rst_lat", lat, 32'd33);
    chk("post_rst_q", quotient, 32'd4);
    chk("post_rst_r", remainder, 32'd1);

    $display("[TB] N=8 sweep");
    edge_a[0] = 8'h80; edge_a[1] = 8'h81; edge_a[2] = 8'hFF; edge_a[3] = 8'h00;
    edge_a[4] = 8'h01; edge_a[5] = 8'h7F; edge_a[6] = 8'hF9; edge_a[7] = 8'h07;
    edge_b[0] = 8'h80; edge_b[1] = 8'hFF; edge_b[2] = 8'h00; edge_b[3] = 8'h01;
    edge_b[4] = 8'h7F; edge_b[5] = 8'hF9; edge_b[6] = 8'h03;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 7; j++) begin
        sweep8(edge_a[i], edge_b[j]);
      end
    end
    for (int k = 0; k < 250; k++) begin
      sweep8(8'($urandom_range(255)), 8'($urandom_range(255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
